// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the RV32I pipeline back end.
//   XLEN          : architectural register width (32)
//   REG_ZERO      : index of the hard-wired zero register x0
//   load_funct3_e : funct3 encodings of the load instructions
//   extByte/extHalf : helpers that sign- or zero-extend a sub-word to XLEN
// No ports; imported by load_align and wb_stage.
// ---------------------------------------------------------------------------
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Load size/sign encodings carried in funct3.
  // The remaining codes (011, 110, 111) are reserved and decode as LW.
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_e;

  // Widen a byte to XLEN, replicating bit 7 when isSigned is set.
  function automatic logic [XLEN-1:0] extByte(input logic [7:0] value,
                                              input logic       isSigned);
    logic fill;
    fill = isSigned & value[7];
    return {{(XLEN-8){fill}}, value};
  endfunction

  // Widen a halfword to XLEN, replicating bit 15 when isSigned is set.
  function automatic logic [XLEN-1:0] extHalf(input logic [15:0] value,
                                              input logic        isSigned);
    logic fill;
    fill = isSigned & value[15];
    return {{(XLEN-16){fill}}, value};
  endfunction

endpackage

// File: rtl/load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Purely combinational load formatter: picks the addressed byte/halfword out
// of the raw aligned data-memory word and extends it to XLEN.
// Ports:
//   i_funct3  in  3     load size/sign (LB, LH, LW, LBU, LHU; reserved -> LW)
//   i_addrLo  in  2     effective-address bits [1:0]
//   i_rawWord in  XLEN  aligned word read from data memory
//   o_value   out XLEN  extended load result
// ---------------------------------------------------------------------------
module load_align
  import rv32i_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addrLo,
  input  logic [XLEN-1:0] i_rawWord,
  output logic [XLEN-1:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte lane selected by the full low address; the halfword lane only looks
  // at bit 1, so a misaligned halfword address simply rounds down.
  always_comb begin
    w_byte = i_rawWord[7:0];
    case (i_addrLo)
      2'd0:    w_byte = i_rawWord[7:0];
      2'd1:    w_byte = i_rawWord[15:8];
      2'd2:    w_byte = i_rawWord[23:16];
      default: w_byte = i_rawWord[31:24];
    endcase
    w_half = i_addrLo[1] ? i_rawWord[31:16] : i_rawWord[15:0];
  end

  // Size/sign decode. Reserved encodings fall into the default arm and
  // therefore behave exactly like LW, with nothing flagged.
  always_comb begin
    o_value = i_rawWord;
    case (i_funct3)
      F3_LB:   o_value = extByte(w_byte, 1'b1);
      F3_LBU:  o_value = extByte(w_byte, 1'b0);
      F3_LH:   o_value = extHalf(w_half, 1'b1);
      F3_LHU:  o_value = extHalf(w_half, 1'b0);
      F3_LW:   o_value = i_rawWord;
      default: o_value = i_rawWord;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
// MEM/WB pipeline register plus register-file write formatting.
// Everything captured on one rising edge of Clk appears on the outputs the
// following cycle; there is no combinational path from inputs to outputs.
// Edge priority: Rst > flush > stall > capture.
//
// Optional feature (macro RETIRE_CNT_EN): 64-bit retired-instruction counter
// exposed on retire_cnt. With the macro undefined neither port nor counter
// exists and all other behaviour is unchanged.
//
// Ports:
//   Clk            in   1           clock, rising edge
//   Rst            in   1           synchronous active-high reset
//   mem_valid      in   1           MEM stage presents an instruction
//   mem_reg_write  in   1           instruction writes a destination register
//   mem_is_load    in   1           result comes from mem_load_data
//   mem_funct3     in   3           load size/sign
//   mem_addr_lo    in   2           effective-address bits [1:0]
//   mem_rd_add     in   5           destination register index
//   mem_alu_result in   Data_width  non-load result
//   mem_load_data  in   Data_width  raw aligned data-memory word
//   stall          in   1           hold the WB register contents
//   flush          in   1           squash the instruction being captured
//   write          out  1           register-file write enable
//   dest_add       out  5           register-file write index
//   dest_data      out  Data_width  register-file write data
//   wb_valid       out  1           WB register holds a live instruction
//   retire_cnt     out  64          retired count (RETIRE_CNT_EN only)
// ---------------------------------------------------------------------------
module wb_stage
  import rv32i_pkg::*;
#(
  parameter int Data_width = 32
)
(
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  mem_valid,
  input  logic                  mem_reg_write,
  input  logic                  mem_is_load,
  input  logic [2:0]            mem_funct3,
  input  logic [1:0]            mem_addr_lo,
  input  logic [4:0]            mem_rd_add,
  input  logic [Data_width-1:0] mem_alu_result,
  input  logic [Data_width-1:0] mem_load_data,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  write,
  output logic [4:0]            dest_add,
  output logic [Data_width-1:0] dest_data,
  output logic                  wb_valid
`ifdef RETIRE_CNT_EN
  ,
  output logic [63:0]           retire_cnt
`endif
);

  logic                  r_write;
  logic [4:0]            r_destAdd;
  logic [Data_width-1:0] r_destData;
  logic                  r_wbValid;

  logic [Data_width-1:0] w_loadValue;
  logic [Data_width-1:0] w_nextData;
  logic                  w_nextWrite;
  logic                  w_capture;

  load_align u_load_align (
    .i_funct3  (mem_funct3),
    .i_addrLo  (mem_addr_lo),
    .i_rawWord (mem_load_data),
    .o_value   (w_loadValue)
  );

  // A capture happens only when nothing of higher priority is active.
  // The write enable folds in the x0 rule here, so a held (stalled) value
  // can never become a write to x0 either.
  always_comb begin
    w_capture   = ~Rst & ~flush & ~stall;
    w_nextWrite = mem_valid & mem_reg_write & (mem_rd_add != REG_ZERO);
    w_nextData  = mem_is_load ? w_loadValue : mem_alu_result;
  end

  // WB register. A flush only clears the two control bits; the data fields
  // are don't-care after a flush, so they simply keep their old contents.
  // A stall holds everything, which makes a repeated register-file write
  // of the same value harmless.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wbValid  <= 1'b0;
      r_write    <= 1'b0;
      r_destAdd  <= '0;
      r_destData <= '0;
    end else if (flush) begin
      r_wbValid  <= 1'b0;
      r_write    <= 1'b0;
    end else if (!stall) begin
      r_wbValid  <= mem_valid;
      r_write    <= w_nextWrite;
      r_destAdd  <= mem_rd_add;
      r_destData <= w_nextData;
    end
  end

  assign write     = r_write;
  assign dest_add  = r_destAdd;
  assign dest_data = r_destData;
  assign wb_valid  = r_wbValid;

`ifdef RETIRE_CNT_EN
  logic [63:0] r_retireCnt;

  // Counts instructions that actually enter WB. Stalled or flushed edges do
  // not count, and the counter wraps naturally at 2^64.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_retireCnt <= '0;
    end else if (w_capture && mem_valid) begin
      r_retireCnt <= r_retireCnt + 64'd1;
    end
  end

  assign retire_cnt = r_retireCnt;
`else
  // Without the counter the capture qualifier has no consumer.
  logic w_unusedCapture;
  assign w_unusedCapture = w_capture;
`endif

endmodule
